// File: rtl/fetch_issue_pkg.sv
// Shared fetch definitions: FSM encodings, instruction size, NOP and a log2 helper.
// No logic of its own: no latency and no backpressure.
package fetch_issue_pkg;

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] NOP         = 32'h0000_0013;

    function automatic int log2_f(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 16; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC priority mux: trap > pending trap > jump > pending jump, plus PC+4.
// Purely combinational; no backpressure.
module fetch_next_pc
    import fetch_issue_pkg::*;
#(
    parameter int ADDRESS_BITS = 32
) (
    input  logic [ADDRESS_BITS-1:0] pc,
    input  logic                    trap,
    input  logic [ADDRESS_BITS-1:0] trap_target,
    input  logic                    jump,
    input  logic [ADDRESS_BITS-1:0] jump_target,
    input  logic                    pend_vld,
    input  logic                    pend_trap,
    input  logic [ADDRESS_BITS-1:0] pend_target,
    output logic                    redirect,
    output logic                    redirect_trap,
    output logic [ADDRESS_BITS-1:0] redirect_target,
    output logic [ADDRESS_BITS-1:0] pc_inc
);

    localparam logic [ADDRESS_BITS-1:0] WORD_MASK = ~(ADDRESS_BITS'(INSTR_BYTES - 1));

    assign pc_inc = pc + ADDRESS_BITS'(INSTR_BYTES);

    // A pending trap must not be displaced by a jump that arrives after it.
    always_comb begin
        redirect        = 1'b0;
        redirect_trap   = 1'b0;
        redirect_target = pend_target;
        if (trap) begin
            redirect        = 1'b1;
            redirect_trap   = 1'b1;
            redirect_target = trap_target & WORD_MASK;
        end else if (pend_vld && pend_trap) begin
            redirect        = 1'b1;
            redirect_trap   = 1'b1;
        end else if (jump) begin
            redirect        = 1'b1;
            redirect_target = jump_target & WORD_MASK;
        end else if (pend_vld) begin
            redirect        = 1'b1;
        end
    end

endmodule

// File: rtl/fetch_issue.sv
// Owns the PC and issues instruction-memory reads; issue_PC/issue_valid one cycle after acceptance.
// Back-pressure: stall holds the PC; a request refused by memory is held unchanged until accepted.
module fetch_issue
    import fetch_issue_pkg::*;
#(
    parameter int                       DATA_WIDTH   = 32,
    parameter int                       ADDRESS_BITS = 32,
    parameter logic [ADDRESS_BITS-1:0]  RESET_PC     = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDRESS_BITS-1:0] program_address,
    input  logic                    trap,
    input  logic [ADDRESS_BITS-1:0] trap_target,
    input  logic                    jump,
    input  logic [ADDRESS_BITS-1:0] jump_target,
    input  logic                    stall,
    input  logic                    i_mem_ready,
    output logic                    i_mem_read,
    output logic [ADDRESS_BITS-1:0] i_mem_read_address,
    output logic [ADDRESS_BITS-1:0] issue_PC,
    output logic                    issue_valid,
    output logic                    flush_out
);

    localparam int OFFSET_BITS = log2_f(DATA_WIDTH / 8);
    localparam logic [ADDRESS_BITS-1:0] ADDR_MASK = ~(ADDRESS_BITS'((1 << OFFSET_BITS) - 1));

    logic [1:0]              state;
    logic [ADDRESS_BITS-1:0] pc;
    logic [ADDRESS_BITS-1:0] issue_pc_q;
    logic                    issue_valid_q;
    logic                    pend_vld;
    logic                    pend_trap;
    logic [ADDRESS_BITS-1:0] pend_target;

    logic                    redirect;
    logic                    redirect_trap;
    logic [ADDRESS_BITS-1:0] redirect_target;
    logic [ADDRESS_BITS-1:0] pc_inc;

    fetch_next_pc #(.ADDRESS_BITS(ADDRESS_BITS)) u_next_pc (
        .pc              (pc),
        .trap            (trap),
        .trap_target     (trap_target),
        .jump            (jump),
        .jump_target     (jump_target),
        .pend_vld        (pend_vld),
        .pend_trap       (pend_trap),
        .pend_target     (pend_target),
        .redirect        (redirect),
        .redirect_trap   (redirect_trap),
        .redirect_target (redirect_target),
        .pc_inc          (pc_inc)
    );

    always_comb begin
        i_mem_read = 1'b0;
        case (state)
            ST_RUN:  i_mem_read = !trap && !jump && !stall;
            ST_WAIT: i_mem_read = 1'b1;
            default: i_mem_read = 1'b0;
        endcase
    end

    assign i_mem_read_address = pc & ADDR_MASK;
    assign issue_PC           = issue_pc_q;
    assign issue_valid        = issue_valid_q;
    assign flush_out          = ~issue_valid_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= ST_BOOT;
            pc            <= RESET_PC;
            issue_pc_q    <= RESET_PC;
            issue_valid_q <= 1'b0;
            pend_vld      <= 1'b0;
            pend_trap     <= 1'b0;
            pend_target   <= '0;
        end else begin
            case (state)
                ST_BOOT: begin
                    if (start) begin
                        pc    <= program_address;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (trap || jump) begin
                        pc            <= redirect_target;
                        issue_valid_q <= 1'b0;
                    end else if (!stall) begin
                        if (i_mem_ready) begin
                            issue_pc_q    <= pc;
                            issue_valid_q <= 1'b1;
                            pc            <= pc_inc;
                        end else begin
                            issue_valid_q <= 1'b0;
                            state         <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (i_mem_ready) begin
                        // Data for the held address is dropped when a redirect is outstanding.
                        if (redirect) begin
                            pc            <= redirect_target;
                            issue_valid_q <= 1'b0;
                            pend_vld      <= 1'b0;
                            pend_trap     <= 1'b0;
                        end else begin
                            issue_pc_q    <= pc;
                            issue_valid_q <= 1'b1;
                            pc            <= pc_inc;
                        end
                        state <= ST_RUN;
                    end else if (trap || jump) begin
                        pend_vld    <= 1'b1;
                        pend_trap   <= redirect_trap;
                        pend_target <= redirect_target;
                    end
                end
                default: state <= ST_BOOT;
            endcase
        end
    end

endmodule
